// File: rtl/uart_rx.sv
// uart_rx: 8N1 receive-only UART with a two-flop input synchronizer, mid-bit
// sampling, and a single-entry holding register behind a valid/ready handshake.
// Framing errors and overruns are reported as one-cycle pulses.
module uart_rx #(
  parameter int unsigned CLK_HZ = 12000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned CW  = $clog2(DIV);

  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  generate
    if (DIV < 4) begin : g_div_check
      $error("uart_rx: clocks per bit (DIV) must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic          meta_q;
  logic          rxs_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;
  logic          tick;

  // Two-flop synchronizer; resets to idle-high so reset release is not a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      rxs_q  <= 1'b1;
    end else begin
      meta_q <= rxd;
      rxs_q  <= meta_q;
    end
  end

  // Receiver state, bit timing counter, shift register and event pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign tick = (cnt_q == '0);

  // Next-state logic: count down to each mid-bit point and act on rxs there.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = CNT_HALF;
        end
      end
      S_START: begin
        if (!tick) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (rxs_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DATA;
          cnt_d   = CNT_FULL;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          shift_d = {rxs_q, shift_q[7:1]};
          cnt_d   = CNT_FULL;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (rxs_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_BREAK;
          ferr_d  = 1'b1;
        end
      end
      S_BREAK: begin
        if (rxs_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Holding register and handshake state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  // A completed byte is accepted if the slot is empty or being drained this
  // cycle; otherwise it is dropped and flagged as an overrun.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (done_q) begin
      if (!valid_q || ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives 8N1 frames clock-aligned on rxd and compares every cycle
// against an event-timed model of the receiver's output register.
module tb_uart_rx;

  localparam int DIV    = 12;
  localparam int FRAME  = 10 * DIV;
  // Cycles from driving the start edge to valid visible: 1 (first flop
  // capture) + 2 + DIV/2 + 9*DIV + 1.
  localparam int T_DONE = 1 + 2 + DIV / 2 + 9 * DIV + 1;
  localparam int T_FERR = T_DONE - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, frame_err, overrun;

  uart_rx #(.CLK_HZ(12000000), .BAUD(1000000)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .data(data), .valid(valid),
    .ready(ready), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scheduled outcomes of the frame currently on the line (-1 = none).
  int         ev_done = -1;
  int         ev_ferr = -1;
  logic [7:0] ev_byte = '0;

  logic [7:0] exp_data  = '0;
  logic       exp_valid = 1'b0;
  logic       exp_ferr  = 1'b0;
  logic       exp_ovr   = 1'b0;

  // Model: the holding register reacts to the scheduled completion/error times.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_data  <= '0;
      exp_valid <= 1'b0;
      exp_ferr  <= 1'b0;
      exp_ovr   <= 1'b0;
    end else begin
      exp_ferr <= (cyc + 1 == ev_ferr);
      exp_ovr  <= 1'b0;
      if (cyc + 1 == ev_done) begin
        if (!exp_valid || ready) begin
          exp_data  <= ev_byte;
          exp_valid <= 1'b1;
        end else begin
          exp_ovr <= 1'b1;
        end
      end else if (exp_valid && ready) begin
        exp_valid <= 1'b0;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  int         ovr_cnt = 0, ferr_cnt = 0, rise_cnt = 0;
  int         rise_cyc = 0, fall_cyc = 0;
  logic [7:0] rise_data = '0;
  logic       valid_prev = 1'b0;

  // Per-cycle comparison plus event monitors used by the directed checks.
  always @(negedge clk) begin
    check("valid", valid, exp_valid);
    check("data", data, exp_data);
    check("frame_err", frame_err, exp_ferr);
    check("overrun", overrun, exp_ovr);
    check("flags_exclusive", frame_err & overrun, 0);
    if (overrun === 1'b1) ovr_cnt++;
    if (frame_err === 1'b1) ferr_cnt++;
    if (valid === 1'b1 && valid_prev !== 1'b1) begin
      rise_cnt++;
      rise_cyc  = cyc;
      rise_data = data;
    end
    if (valid_prev === 1'b1 && valid !== 1'b1) fall_cyc = cyc;
    valid_prev = valid;
  end

  task automatic idle(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      if (mode == 2) ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  // mode 0: ready untouched; 1: ready high only for the completion edge;
  // 2: random ready each cycle. abort_c >= 0 asserts rst at that bit-cycle.
  task automatic send(input logic [7:0] b, input bit stop_ok, input int mode, input int abort_c);
    logic [9:0] bits;
    int n;
    bits = {stop_ok, b, 1'b0};
    n = cyc;
    if (stop_ok) begin
      ev_byte = b;
      ev_done = n + T_DONE;
    end else begin
      ev_ferr = n + T_FERR;
    end
    for (int c = 0; c < FRAME; c++) begin
      if (c == abort_c) begin
        rst = 1'b1;
        rxd = 1'b1;
        ev_done = -1;
        ev_ferr = -1;
        return;
      end
      rxd = bits[c / DIV];
      if (mode == 1) ready = (c == T_DONE - 1);
      else if (mode == 2) ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n0, o, f, r;
    logic [7:0] b;
    bit ok;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(100, 0);
    check("reset_valid", valid, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun", overrun, 0);
    check("reset_data", data, 8'h00);

    // Single byte with ready held high: one-cycle valid, 117-clock latency.
    ready = 1'b1;
    r = rise_cnt;
    n0 = cyc;
    send(8'hA5, 1'b1, 0, -1);
    check("a5_rises", rise_cnt - r, 1);
    check("a5_data", rise_data, 8'hA5);
    check("a5_latency", rise_cyc - (n0 + 1), 117);
    check("a5_width", fall_cyc - rise_cyc, 1);

    // Back-to-back frames with no consumer: second byte overruns.
    ready = 1'b0;
    o = ovr_cnt;
    send(8'h3C, 1'b1, 0, -1);
    send(8'hC3, 1'b1, 0, -1);
    check("ovr_data", data, 8'h3C);
    check("ovr_valid", valid, 1);
    check("ovr_pulses", ovr_cnt - o, 1);
    ready = 1'b1;
    idle(1, 0);
    check("ovr_drain_valid", valid, 0);
    ready = 1'b0;

    // Consume on the exact completion cycle: replace without overrun.
    idle(5, 0);
    send(8'h3C, 1'b1, 0, -1);
    o = ovr_cnt;
    send(8'h55, 1'b1, 1, -1);
    check("swap_data", data, 8'h55);
    check("swap_valid", valid, 1);
    check("swap_no_ovr", ovr_cnt - o, 0);
    ready = 1'b1;
    idle(1, 0);
    ready = 1'b0;

    // Short glitch is a false start; next frame still decodes.
    r = rise_cnt;
    rxd = 1'b0;
    idle(4, 0);
    rxd = 1'b1;
    idle(30, 0);
    check("glitch_no_valid", rise_cnt - r, 0);
    ready = 1'b1;
    send(8'h81, 1'b1, 0, -1);
    check("glitch_next_rises", rise_cnt - r, 1);
    check("glitch_next_data", rise_data, 8'h81);

    // Stop bit low then held break; single frame_err, later frame fine.
    f = ferr_cnt;
    r = rise_cnt;
    send(8'h5A, 1'b0, 0, -1);
    idle(50, 0);
    rxd = 1'b1;
    idle(20, 0);
    check("break_ferr_pulses", ferr_cnt - f, 1);
    check("break_no_valid", rise_cnt - r, 0);
    send(8'h7E, 1'b1, 0, -1);
    check("break_next_rises", rise_cnt - r, 1);
    check("break_next_data", rise_data, 8'h7E);

    // Reset in the middle of a data bit while a byte is held.
    ready = 1'b0;
    send(8'h99, 1'b1, 0, -1);
    check("pre_reset_valid", valid, 1);
    send(8'hF0, 1'b1, 0, 40);
    #1;
    check("midreset_valid", valid, 0);
    check("midreset_data", data, 8'h00);
    check("midreset_frame_err", frame_err, 0);
    check("midreset_overrun", overrun, 0);
    idle(3, 0);
    rst = 1'b0;
    idle(20, 0);
    ready = 1'b1;
    r = rise_cnt;
    send(8'h12, 1'b1, 0, -1);
    check("post_reset_rises", rise_cnt - r, 1);
    check("post_reset_data", rise_data, 8'h12);

    // Random traffic with random consumer; the per-cycle compare does the work.
    for (int k = 0; k < 40; k++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      send(b, ok, 2, -1);
      if (!ok) begin
        idle($urandom_range(0, 30), 2);
        rxd = 1'b1;
        idle($urandom_range(3, 20), 2);
      end else begin
        idle($urandom_range(0, 25), 2);
      end
    end
    ready = 1'b0;
    idle(10, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive-only UART for the FTDI FT2232H channel (rs232_rxd pin) on the iCEstick.
- Delivers bytes to the board top over a valid/ready handshake.
- Format fixed at 8N1; each byte drives the LED bank or a downstream consumer.
- Flags framing errors and overruns so the top can show them on a spare LED.

Parameters:
- CLK_HZ, 12000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- DIV, derived (localparam) = (CLK_HZ + BAUD/2) / BAUD; clocks per bit. Default 104. Must be >= 4; elaboration error otherwise.

Ports:
- clk  input  1  12 MHz system clock.
- rst  input  1  reset; asynchronous, active-high.
- rxd  input  1  raw serial line, idle high; asynchronous to clk.
- data  output  8  received byte, LSB = first data bit.
- valid  output  1  data holds an unconsumed byte.
- ready  input  1  consumer accepts data when valid & ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte dropped because the holding register was full.

Behaviour:
- Reset (async, active-high) values:
  - data = 0, valid = 0, frame_err = 0, overrun = 0.
  - FSM = IDLE; bit counter and clock counter = 0.
  - Both synchronizer flops = 1, so reset release never fakes a start bit.
- Reset mid-frame abandons the frame with no flag.
- Synchronizer: rxd passes through 2 flops. rxs is the second flop output; all decisions use rxs only.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - On rxs = 0, go to START and load cnt = DIV/2 - 1.
- START:
  - cnt decrements each clock. At cnt = 0, sample rxs (mid start bit).
  - rxs = 1: false start, go to IDLE.
  - rxs = 0: load cnt = DIV - 1, bit index = 0, go to DATA.
- DATA:
  - At cnt = 0, shift rxs into the shift register MSB (LSB-first line order) and reload cnt = DIV - 1.
  - After index 7 is sampled, go to STOP.
- STOP:
  - At cnt = 0, sample rxs.
  - rxs = 1: byte complete, go to IDLE (a new start may be detected the next cycle).
  - rxs = 0: frame_err pulses 1 cycle, byte discarded, go to BREAK.
- BREAK:
  - Stay until rxs = 1, then go to IDLE. Prevents re-triggering on a held-low line.
- Byte complete (registered on the cycle after the mid-stop sample):
  - valid = 0: data <= shift register, valid <= 1.
  - valid = 1 and ready = 1 the same cycle: old byte is consumed, data <= new byte, valid stays 1, no overrun.
  - valid = 1 and ready = 0: new byte dropped, data unchanged, overrun pulses 1 cycle.
- Handshake:
  - valid & ready with no completion that cycle: valid <= 0 next cycle.
  - data is stable while valid = 1.
  - ready is ignored when valid = 0.
  - valid never depends combinationally on ready.
- Latency: from the rxd falling edge to valid high, with the edge sampled at clock edge t0, valid rises at t0 + 2 + DIV/2 + 9*DIV + 1 clocks (+/-1 for edge phase).
- frame_err and overrun are never asserted in the same cycle as each other.

Test Plan:
- Use CLK_HZ=12000000, BAUD=1000000 (DIV=12) throughout.
- Reset, rxd held 1 for 100 clocks -> valid = 0, frame_err = 0, overrun = 0, data = 0x00.
- Send 0xA5 8N1, ready = 1 -> valid high exactly 1 cycle, data = 0xA5, rise ~117 clocks after the start edge (+/-1).
- Send 0x3C then 0xC3 back-to-back (1 stop bit), ready = 0 -> data = 0x3C, valid stays 1, overrun pulses once at the second completion. Raise ready -> valid drops next cycle.
- Send 0x55 with ready = 1 asserted on the exact completion cycle of a held 0x3C -> data becomes 0x55, valid stays 1, no overrun.
- Glitch: rxd low for 4 clocks, then high -> no valid, FSM back in IDLE. A following 0x81 frame is received correctly.
- Stop bit forced 0, then line held low 50 clocks, then high, then send 0x7E:
  - frame_err pulses once and no valid for the bad frame.
  - 0x7E is received afterward.
  - Separately, assert rst mid-DATA -> all outputs 0 immediately; next frame 0x12 is received correctly.
